// File: rtl/apu_pkg.sv
// apu_pkg: shared constants and types for the APU DMC sample-fetch slice.
//   DMC_BASE / DMC_WRAP : sample region base and the address an
//                         incrementing fetch wraps to after 16'hFFFF
//   REG_*               : register-select codes on the ADDR bus
//   REM_W               : width of the bytes-remaining down-counter
//   dmc_state_t         : fetch FSM states
//   dmc_next_addr()     : post-fetch address increment with wrap
package apu_pkg;

   localparam logic [15:0] DMC_BASE = 16'hC000;
   localparam logic [15:0] DMC_WRAP = 16'h8000;

   localparam logic [1:0] REG_CTRL = 2'd0;   // $4010
   localparam logic [1:0] REG_ADDR = 2'd2;   // $4012
   localparam logic [1:0] REG_LEN  = 2'd3;   // $4013

   localparam int REM_W = 12;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } dmc_state_t;

   function automatic logic [15:0] dmc_next_addr(input logic [15:0] addr);
      return (addr == 16'hFFFF) ? DMC_WRAP : addr + 16'd1;
   endfunction

endpackage

// File: rtl/apu_sync_fifo.sv
// apu_sync_fifo: single-clock FIFO holding fetched DMC sample bytes.
//   clk, reset (async, active-low)
//   push / push_data : write one entry (dropped if full and not popping)
//   pop              : remove head entry (ignored when empty)
//   head_data        : head entry, 0 when empty
//   not_empty        : at least one entry held
//   level            : number of entries held
// DEPTH must be a power of two so the pointers wrap naturally.
module apu_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             not_empty,
   output logic [LVL_W-1:0] level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop    = pop && (level != '0);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push   = push && ((level != LVL_W'(DEPTH)) || do_pop);
   assign not_empty = (level != '0);
   assign head_data = not_empty ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/apu_dmc_fetch.sv
// apu_dmc_fetch: DMC sample-fetch engine. Holds the DMC address/length
// registers, fetches sample bytes through the DmaReq/DmaAck handshake and
// buffers them in a FIFO for the DMC output unit.
//
// Ports
//   clk, reset        clock, async active-low reset
//   ce                APU clock enable, gates request launch only
//   ADDR, DIN, MW     register select / data / write strobe ($4010/12/13)
//   dmc_en_wr, dmc_en $4015 write strobe and bit 4
//   DmaReq, DmaAddr   fetch request and address (held while DmaReq=1)
//   DmaAck, DmaData   fetch completion and fetched byte
//   sample_pop        output unit consumes the head byte
//   sample_data       head byte, sample_valid: FIFO non-empty
//   fifo_level        bytes buffered
//   active            bytes remaining != 0
//   IRQ               end-of-sample interrupt
//
// Build option: define APU_DMC_IRQ_EN to build the interrupt logic. Without
// it IRQ is tied low and the irq_en control bit is stored but has no effect.
//
// Fetch FSM
//   state | meaning
//   IDLE  | no fetch in flight; launch on ce when bytes remain and FIFO has room
//   REQ   | DmaReq high at DmaAddr until DmaAck; byte dropped if disabled meanwhile
module apu_dmc_fetch
   import apu_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ce,
   input  logic [1:0]       ADDR,
   input  logic [7:0]       DIN,
   input  logic             MW,
   input  logic             dmc_en_wr,
   input  logic             dmc_en,
   output logic             DmaReq,
   input  logic             DmaAck,
   output logic [15:0]      DmaAddr,
   input  logic [7:0]       DmaData,
   input  logic             sample_pop,
   output logic [7:0]       sample_data,
   output logic             sample_valid,
   output logic [LVL_W-1:0] fifo_level,
   output logic             active,
   output logic             IRQ
);

   logic             irq_en;
   logic             loop_en;
   logic [15:0]      start_addr;
   logic [REM_W-1:0] length;

   dmc_state_t       state;
   logic [15:0]      cur_addr;
   logic [REM_W-1:0] remaining;
   logic             discard;

   logic             disable_wr;
   logic             ack_ok;
   logic             push_byte;
   logic             fifo_has_room;
   logic             last_byte;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq_en     <= 1'b0;
         loop_en    <= 1'b0;
         start_addr <= DMC_BASE;
         length     <= REM_W'(1);
      end else if (MW) begin
         case (ADDR)
            REG_CTRL: begin
               irq_en  <= DIN[7];
               loop_en <= DIN[6];
            end
            REG_ADDR: start_addr <= DMC_BASE + {2'b00, DIN, 6'b000000};
            REG_LEN:  length     <= {DIN, 4'b0000} + REM_W'(1);
            default:  ;
         endcase
      end
   end

   assign disable_wr    = dmc_en_wr && !dmc_en;
   assign ack_ok        = (state == REQ) && DmaAck;
   // A byte fetched while the channel was disabled belongs to no sample.
   assign push_byte     = ack_ok && !discard && !disable_wr;
   assign fifo_has_room = (fifo_level < LVL_W'(FIFO_DEPTH));
   assign last_byte     = (remaining == REM_W'(1));
   assign active        = (remaining != '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         DmaReq    <= 1'b0;
         DmaAddr   <= DMC_BASE;
         cur_addr  <= DMC_BASE;
         remaining <= '0;
         discard   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // Only one fetch is ever in flight, so room checked here is
               // still free when its byte arrives.
               if (ce && (remaining != '0) && fifo_has_room) begin
                  state   <= REQ;
                  DmaReq  <= 1'b1;
                  DmaAddr <= cur_addr;
                  discard <= disable_wr;
               end
            end
            REQ: begin
               if (DmaAck) begin
                  state   <= IDLE;
                  DmaReq  <= 1'b0;
                  discard <= 1'b0;
                  if (push_byte) begin
                     if (last_byte && loop_en) begin
                        cur_addr  <= start_addr;
                        remaining <= length;
                     end else begin
                        cur_addr  <= dmc_next_addr(cur_addr);
                        remaining <= remaining - REM_W'(1);
                     end
                  end
               end else if (disable_wr) begin
                  discard <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         // $4015 writes take priority over the fetch-side counter update.
         if (dmc_en_wr) begin
            if (!dmc_en) begin
               remaining <= '0;
            end else if (remaining == '0) begin
               cur_addr  <= start_addr;
               remaining <= length;
            end
         end
      end
   end

`ifdef APU_DMC_IRQ_EN
   logic irq_set;
   logic irq_clr;

   assign irq_set = push_byte && last_byte && !loop_en && irq_en;
   assign irq_clr = dmc_en_wr || (MW && (ADDR == REG_CTRL) && !DIN[7]);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       IRQ <= 1'b0;
      else if (irq_clr) IRQ <= 1'b0;
      else if (irq_set) IRQ <= 1'b1;
   end
`else
   logic irq_en_unused;

   assign IRQ           = 1'b0;
   assign irq_en_unused = irq_en;
`endif

   apu_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8),
      .LVL_W (LVL_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_byte),
      .push_data (DmaData),
      .pop       (sample_pop),
      .head_data (sample_data),
      .not_empty (sample_valid),
      .level     (fifo_level)
   );

endmodule

// File: tb/tb_apu_dmc_fetch.sv
module tb_apu_dmc_fetch;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;
`ifdef APU_DMC_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          ce = 1'b0;
   logic [1:0]    ADDR = '0;
   logic [7:0]    DIN = '0;
   logic          MW = 1'b0;
   logic          dmc_en_wr = 1'b0;
   logic          dmc_en = 1'b0;
   logic          DmaAck = 1'b0;
   logic [7:0]    DmaData = '0;
   logic          sample_pop = 1'b0;
   logic          DmaReq;
   logic [15:0]   DmaAddr;
   logic [7:0]    sample_data;
   logic          sample_valid;
   logic [LW-1:0] fifo_level;
   logic          active;
   logic          IRQ;

   int total = 0;
   int bad   = 0;

   apu_dmc_fetch #(.FIFO_DEPTH(DEPTH), .LVL_W(LW)) dut (
      .clk(clk), .reset(reset), .ce(ce), .ADDR(ADDR), .DIN(DIN), .MW(MW),
      .dmc_en_wr(dmc_en_wr), .dmc_en(dmc_en), .DmaReq(DmaReq), .DmaAck(DmaAck),
      .DmaAddr(DmaAddr), .DmaData(DmaData), .sample_pop(sample_pop),
      .sample_data(sample_data), .sample_valid(sample_valid),
      .fifo_level(fifo_level), .active(active), .IRQ(IRQ)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      ADDR = a; DIN = d; MW = 1'b1;
      tick();
      MW = 1'b0;
   endtask

   task automatic en(input logic v);
      dmc_en = v; dmc_en_wr = 1'b1;
      tick();
      dmc_en_wr = 1'b0;
   endtask

   task automatic pop1();
      sample_pop = 1'b1;
      tick();
      sample_pop = 1'b0;
   endtask

   task automatic wait_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (DmaReq) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic ack(input logic [7:0] d);
      DmaData = d; DmaAck = 1'b1;
      tick();
      DmaAck = 1'b0;
   endtask

   task automatic fetch(input logic [7:0] d, input logic with_pop,
                        output logic [15:0] a, output bit ok);
      wait_req(ok);
      a = DmaAddr;
      if (ok) begin
         DmaData = d; DmaAck = 1'b1; sample_pop = with_pop;
         tick();
         DmaAck = 1'b0; sample_pop = 1'b0;
      end
   endtask

   task automatic quiet(input int n, output bit seen);
      seen = 1'b0;
      repeat (n) begin
         tick();
         if (DmaReq) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      total++; if (DmaReq !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h exp=0", DmaReq); end
      total++; if (DmaAddr !== 16'hC000) begin bad++; $display("FAIL rst_addr got=%h exp=c000", DmaAddr); end
      total++; if (sample_data !== 8'h00 || sample_valid !== 1'b0) begin bad++; $display("FAIL rst_sample got=%h/%0h exp=00/0", sample_data, sample_valid); end
      total++; if (fifo_level !== LW'(0) || active !== 1'b0 || IRQ !== 1'b0) begin bad++; $display("FAIL rst_misc got lvl=%0d act=%0h irq=%0h exp=0/0/0", fifo_level, active, IRQ); end
   endtask

   task automatic test_basic();
      logic [15:0] a; bit ok; bit seen;
      wr(2'd2, 8'h00); wr(2'd3, 8'h01); en(1'b1);
      total++; if (active !== 1'b1) begin bad++; $display("FAIL basic_active_on got=%0h exp=1", active); end
      for (int i = 0; i < 17; i++) begin
         fetch(8'h11 + 8'(i), (i > 0), a, ok);
         total++; if (!ok || a !== 16'hC000 + 16'(i)) begin bad++; $display("FAIL basic_addr[%0d] got=%h ok=%0d exp=%h", i, a, ok, 16'hC000 + 16'(i)); end
         total++; if (sample_data !== 8'h11 + 8'(i) || fifo_level !== LW'(1)) begin bad++; $display("FAIL basic_data[%0d] got=%h lvl=%0d exp=%h lvl=1", i, sample_data, fifo_level, 8'h11 + 8'(i)); end
      end
      total++; if (active !== 1'b0) begin bad++; $display("FAIL basic_active_off got=%0h exp=0", active); end
      total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL basic_irq got=%0h exp=0", IRQ); end
      quiet(10, seen);
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL basic_no_more_req got=%0d exp=0", seen); end
      pop1();
      total++; if (sample_valid !== 1'b0 || fifo_level !== LW'(0)) begin bad++; $display("FAIL basic_empty got=%0h/%0d exp=0/0", sample_valid, fifo_level); end
   endtask

   task automatic test_timing();
      bit seen;
      ce = 1'b0;
      en(1'b1);
      quiet(5, seen);
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL ce_gate got=%0d exp=0", seen); end
      ce = 1'b1;
      tick();
      total++; if (DmaReq !== 1'b1 || DmaAddr !== 16'hC000) begin bad++; $display("FAIL ce_launch got=%0h/%h exp=1/c000", DmaReq, DmaAddr); end
      ack(8'h77);
      total++; if (DmaReq !== 1'b0) begin bad++; $display("FAIL req_fall got=%0h exp=0", DmaReq); end
      total++; if (sample_valid !== 1'b1 || sample_data !== 8'h77) begin bad++; $display("FAIL first_byte got=%0h/%h exp=1/77", sample_valid, sample_data); end
      tick();
      total++; if (DmaReq !== 1'b1 || DmaAddr !== 16'hC001) begin bad++; $display("FAIL b2b_req got=%0h/%h exp=1/c001", DmaReq, DmaAddr); end
      en(1'b0);
      total++; if (DmaReq !== 1'b1 || active !== 1'b0) begin bad++; $display("FAIL dis_hold got=%0h/%0h exp=1/0", DmaReq, active); end
      ack(8'h66);
      total++; if (DmaReq !== 1'b0 || fifo_level !== LW'(1) || sample_data !== 8'h77) begin bad++; $display("FAIL dis_drop got=%0h/%0d/%h exp=0/1/77", DmaReq, fifo_level, sample_data); end
      quiet(8, seen);
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL dis_quiet got=%0d exp=0", seen); end
      pop1();
   endtask

   task automatic test_full();
      logic [15:0] a; bit ok; bit seen;
      wr(2'd2, 8'h00); wr(2'd3, 8'h01); en(1'b1);
      for (int i = 0; i < 4; i++) begin
         fetch(8'hA0 + 8'(i), 1'b0, a, ok);
         total++; if (!ok || a !== 16'hC000 + 16'(i)) begin bad++; $display("FAIL full_addr[%0d] got=%h ok=%0d exp=%h", i, a, ok, 16'hC000 + 16'(i)); end
      end
      total++; if (fifo_level !== LW'(4)) begin bad++; $display("FAIL full_level got=%0d exp=4", fifo_level); end
      quiet(10, seen);
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL full_stall got=%0d exp=0", seen); end
      pop1();
      fetch(8'hA4, 1'b0, a, ok);
      total++; if (!ok || a !== 16'hC004 || fifo_level !== LW'(4)) begin bad++; $display("FAIL full_refill got=%h ok=%0d lvl=%0d exp=c004 lvl=4", a, ok, fifo_level); end
      en(1'b0);
      for (int k = 1; k <= 4; k++) begin
         total++; if (sample_data !== 8'hA0 + 8'(k)) begin bad++; $display("FAIL full_order[%0d] got=%h exp=%h", k, sample_data, 8'hA0 + 8'(k)); end
         pop1();
      end
      total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL full_drained got=%0h exp=0", sample_valid); end
   endtask

   task automatic test_wrap();
      logic [15:0] a; logic [15:0] exp; bit ok;
      wr(2'd2, 8'hFF); wr(2'd3, 8'h04); en(1'b1);
      for (int i = 0; i < 65; i++) begin
         exp = (i < 64) ? 16'hFFC0 + 16'(i) : 16'h8000;
         fetch(8'(i), (i > 0), a, ok);
         total++; if (!ok || a !== exp) begin bad++; $display("FAIL wrap_addr[%0d] got=%h ok=%0d exp=%h", i, a, ok, exp); end
      end
      total++; if (active !== 1'b0 || sample_data !== 8'd64) begin bad++; $display("FAIL wrap_end got=%0h/%h exp=0/40", active, sample_data); end
      pop1();
   endtask

   task automatic test_disable();
      logic [15:0] a; bit ok; bit seen;
      wr(2'd2, 8'h00); wr(2'd3, 8'h01); en(1'b1);
      wait_req(ok);
      total++; if (!ok) begin bad++; $display("FAIL dis_wait got=timeout exp=request"); end
      wr(2'd2, 8'h10);
      total++; if (DmaReq !== 1'b1 || DmaAddr !== 16'hC000) begin bad++; $display("FAIL wr_in_req got=%0h/%h exp=1/c000", DmaReq, DmaAddr); end
      en(1'b0);
      total++; if (DmaReq !== 1'b1 || active !== 1'b0) begin bad++; $display("FAIL dis2_hold got=%0h/%0h exp=1/0", DmaReq, active); end
      ack(8'h55);
      total++; if (DmaReq !== 1'b0 || fifo_level !== LW'(0) || sample_valid !== 1'b0) begin bad++; $display("FAIL dis2_drop got=%0h/%0d/%0h exp=0/0/0", DmaReq, fifo_level, sample_valid); end
      quiet(8, seen);
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL dis2_quiet got=%0d exp=0", seen); end
      en(1'b1);
      fetch(8'h5A, 1'b0, a, ok);
      total++; if (!ok || a !== 16'hC400) begin bad++; $display("FAIL new_start got=%h ok=%0d exp=c400", a, ok); end
      wait_req(ok);
      en(1'b0);
      ack(8'h5B);
      total++; if (fifo_level !== LW'(1) || sample_data !== 8'h5A) begin bad++; $display("FAIL dis3_drop got=%0d/%h exp=1/5a", fifo_level, sample_data); end
      pop1();
   endtask

   task automatic test_irq();
      logic [15:0] a; bit ok;
      wr(2'd0, 8'h80); wr(2'd2, 8'hFF); wr(2'd3, 8'h00); en(1'b1);
      fetch(8'hE1, 1'b0, a, ok);
      total++; if (!ok || a !== 16'hFFC0) begin bad++; $display("FAIL irq_addr got=%h ok=%0d exp=ffc0", a, ok); end
      total++; if (IRQ !== IRQ_ON || active !== 1'b0) begin bad++; $display("FAIL irq_set got=%0h/%0h exp=%0h/0", IRQ, active, IRQ_ON); end
      en(1'b0);
      total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL irq_clr_4015 got=%0h exp=0", IRQ); end
      pop1();
      en(1'b1);
      fetch(8'hE2, 1'b0, a, ok);
      total++; if (!ok || IRQ !== IRQ_ON) begin bad++; $display("FAIL irq_set2 got=%0h ok=%0d exp=%0h", IRQ, ok, IRQ_ON); end
      wr(2'd0, 8'h00);
      total++; if (IRQ !== 1'b0) begin bad++; $display("FAIL irq_clr_4010 got=%0h exp=0", IRQ); end
      pop1();
      wr(2'd0, 8'h80); en(1'b1);
      wait_req(ok);
      total++; if (!ok || IRQ !== 1'b0) begin bad++; $display("FAIL irq_pre got=%0h ok=%0d exp=0", IRQ, ok); end
      DmaData = 8'hE3; DmaAck = 1'b1; dmc_en = 1'b1; dmc_en_wr = 1'b1;
      tick();
      DmaAck = 1'b0; dmc_en_wr = 1'b0;
      total++; if (IRQ !== 1'b0 || active !== 1'b0 || fifo_level !== LW'(1)) begin bad++; $display("FAIL irq_clr_wins got=%0h/%0h/%0d exp=0/0/1", IRQ, active, fifo_level); end
      pop1();
      wr(2'd0, 8'h00);
   endtask

   task automatic test_loop();
      logic [15:0] a; bit ok;
      wr(2'd0, 8'hC0); wr(2'd2, 8'h00); wr(2'd3, 8'h00); en(1'b1);
      for (int i = 0; i < 5; i++) begin
         fetch(8'hB0 + 8'(i), (i > 0), a, ok);
         total++; if (!ok || a !== 16'hC000) begin bad++; $display("FAIL loop_addr[%0d] got=%h ok=%0d exp=c000", i, a, ok); end
         total++; if (active !== 1'b1 || IRQ !== 1'b0) begin bad++; $display("FAIL loop_state[%0d] got=%0h/%0h exp=1/0", i, active, IRQ); end
      end
      wait_req(ok);
      en(1'b0);
      ack(8'hBF);
      total++; if (fifo_level !== LW'(1) || sample_data !== 8'hB4) begin bad++; $display("FAIL loop_stop got=%0d/%h exp=1/b4", fifo_level, sample_data); end
      pop1();
      wr(2'd0, 8'h00);
   endtask

   task automatic test_reset_mid();
      logic [15:0] a; bit ok;
      wr(2'd2, 8'h00); wr(2'd3, 8'h01); en(1'b1);
      fetch(8'h99, 1'b0, a, ok);
      wait_req(ok);
      total++; if (!ok || fifo_level !== LW'(1)) begin bad++; $display("FAIL mid_setup got=ok%0d lvl=%0d exp=ok1 lvl=1", ok, fifo_level); end
      reset = 1'b0;
      #1;
      total++; if (DmaReq !== 1'b0 || DmaAddr !== 16'hC000) begin bad++; $display("FAIL mid_rst_req got=%0h/%h exp=0/c000", DmaReq, DmaAddr); end
      total++; if (fifo_level !== LW'(0) || sample_valid !== 1'b0 || sample_data !== 8'h00 || active !== 1'b0) begin bad++; $display("FAIL mid_rst_fifo got=%0d/%0h/%h/%0h exp=0/0/00/0", fifo_level, sample_valid, sample_data, active); end
      tick();
      reset = 1'b1;
      tick();
      en(1'b1);
      fetch(8'h42, 1'b0, a, ok);
      total++; if (!ok || a !== 16'hC000 || active !== 1'b0 || sample_data !== 8'h42) begin bad++; $display("FAIL post_rst got=%h ok=%0d act=%0h d=%h exp=c000 act=0 d=42", a, ok, active, sample_data); end
      pop1();
   endtask

   initial begin
      reset = 1'b0;
      ce = 1'b1;
      repeat (3) tick();
      test_reset();
      reset = 1'b1;
      tick();
      test_basic();
      test_timing();
      test_full();
      test_wrap();
      test_disable();
      test_irq();
      test_loop();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
